// File: rtl/t_input_conditioner.sv
// t_input_conditioner: synchronizes and debounces a bouncy pad toggle
// request, emits a single-cycle strobe on each accepted rising edge and
// counts the accepted rising edges.
module t_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             t_raw,
  input  logic             count_clr,
  output logic             t_pulse,
  output logic             t_level,
  output logic             busy,
  output logic [CNT_W-1:0] toggle_count
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  logic [7:0]       r_cnt;
  logic             r_pulse;
  logic             r_level;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic             w_tsync;
  logic             w_qualified;
  logic             w_accept;

  assign w_tsync     = r_sync2;
  assign w_qualified = (r_cnt == LAST_CNT);
  // A rising edge is accepted on exactly the edge that sets t_pulse.
  assign w_accept    = ena && (r_state == RISE_WAIT) && w_tsync && w_qualified;

  assign t_pulse      = r_pulse;
  assign t_level      = r_level;
  assign busy         = r_busy;
  assign toggle_count = r_count;

  // Two-flop synchronizer for the pad input; keeps running while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= t_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM with registered pulse, level and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOW;
      r_cnt   <= 8'd0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      if (ena) begin
        case (r_state)
          LOW: begin
            if (w_tsync) begin
              r_state <= RISE_WAIT;
              r_cnt   <= 8'd0;
              r_busy  <= 1'b1;
            end
          end
          RISE_WAIT: begin
            if (!w_tsync) begin
              r_state <= LOW;
              r_busy  <= 1'b0;
            end else if (w_qualified) begin
              r_state <= HIGH;
              r_level <= 1'b1;
              r_busy  <= 1'b0;
              r_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          HIGH: begin
            if (!w_tsync) begin
              r_state <= FALL_WAIT;
              r_cnt   <= 8'd0;
              r_busy  <= 1'b1;
            end
          end
          FALL_WAIT: begin
            if (w_tsync) begin
              r_state <= HIGH;
              r_busy  <= 1'b0;
            end else if (w_qualified) begin
              r_state <= LOW;
              r_level <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= LOW;
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Accepted-edge counter; clear beats increment and works while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (count_clr) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_t_input_conditioner.sv
// Testbench for t_input_conditioner: a table of per-edge vectors for the
// clean press/release path, then hand-written multi-cycle corner cases.
module tb_t_input_conditioner;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       t_raw;
  logic       count_clr;
  logic       t_pulse;
  logic       t_level;
  logic       busy;
  logic [7:0] toggle_count;

  int total;
  int bad;

  typedef struct {
    logic       rst;
    logic       ena;
    logic       raw;
    logic       clr;
    logic       ePulse;
    logic       eLevel;
    logic       eBusy;
    logic [7:0] eCount;
  } vec_t;

  vec_t vecs[20];

  t_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .t_raw(t_raw),
    .count_clr(count_clr),
    .t_pulse(t_pulse),
    .t_level(t_level),
    .busy(busy),
    .toggle_count(toggle_count)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs at the falling edge, then sample 1 unit after the rising edge.
  task automatic applyStimulus(input logic iRst, input logic iEna,
                               input logic iRaw, input logic iClr);
    @(negedge clk);
    rst       = iRst;
    ena       = iEna;
    t_raw     = iRaw;
    count_clr = iClr;
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic w,
                              input logic c, input logic p, input logic l,
                              input logic b, input logic [7:0] n);
    vec_t v;
    v.rst = r; v.ena = e; v.raw = w; v.clr = c;
    v.ePulse = p; v.eLevel = l; v.eBusy = b; v.eCount = n;
    return v;
  endfunction

  // Main sequence: table vectors, then corner cases, then summary.
  initial begin
    int pulses;
    int relPulses;
    total = 0;
    bad   = 0;
    rst = 1'b1; ena = 1'b1; t_raw = 1'b0; count_clr = 1'b0;

    // rst ena raw clr | pulse level busy count
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); // edge 0
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0); // edge 1
    vecs[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0); // edge 2
    vecs[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0); // edge 5
    vecs[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1); // edge 6
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    vecs[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1); // release
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1); // FALL_WAIT
    vecs[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
    vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
    vecs[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
    vecs[16] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1); // LOW
    vecs[17] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0); // clr, ena=0
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ena, vecs[i].raw, vecs[i].clr);
      checkOutput($sformatf("vec%0d_pulse", i), {7'd0, t_pulse}, {7'd0, vecs[i].ePulse});
      checkOutput($sformatf("vec%0d_level", i), {7'd0, t_level}, {7'd0, vecs[i].eLevel});
      checkOutput($sformatf("vec%0d_busy", i),  {7'd0, busy},    {7'd0, vecs[i].eBusy});
      checkOutput($sformatf("vec%0d_count", i), toggle_count,    vecs[i].eCount);
    end

    // Press bounce: high 2, low 1, then held high -> one pulse.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      if (t_pulse) pulses++;
    end
    checkOutput("bounce_pulses", 8'(pulses), 8'd1);
    checkOutput("bounce_count", toggle_count, 8'd1);

    // 256 clean press/release cycles: counter wraps, releases never pulse.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    pulses = 0;
    relPulses = 0;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        if (t_pulse) pulses++;
      end
      for (int i = 0; i < 10; i++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        if (t_pulse) relPulses++;
      end
      if (k == 254) checkOutput("wrap_count_255", toggle_count, 8'd255);
    end
    checkOutput("wrap_press_pulses", 8'(pulses - 256), 8'd0);
    checkOutput("wrap_release_pulses", 8'(relPulses), 8'd0);
    checkOutput("wrap_count", toggle_count, 8'd0);

    // Clear on the same edge that sets the pulse: clear wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); // edges 0..5
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);                              // edge 6
    checkOutput("clrhit_pulse", {7'd0, t_pulse}, 8'd1);
    checkOutput("clrhit_count", toggle_count, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("clrhit_count_after", toggle_count, 8'd0);

    // Freeze in RISE_WAIT with cnt=2, then resume: pulse on second enabled edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0); // edges 0..4
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      if (t_pulse) pulses++;
      if (i == 9) checkOutput("freeze_busy", {7'd0, busy}, 8'd1);
    end
    checkOutput("freeze_pulses", 8'(pulses), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("resume1_pulse", {7'd0, t_pulse}, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("resume2_pulse", {7'd0, t_pulse}, 8'd1);
    checkOutput("resume2_count", toggle_count, 8'd1);

    // Reset mid-qualification discards the edge; fresh qualification needed.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_busy_before", {7'd0, busy}, 8'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_outs", {4'd0, t_pulse, t_level, busy, 1'b0}, 8'd0);
    checkOutput("midrst_count", toggle_count, 8'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      if (t_pulse) pulses++;
    end
    checkOutput("midrst_no_early_pulse", 8'(pulses), 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("midrst_fresh_pulse", {7'd0, t_pulse}, 8'd1);
    checkOutput("midrst_fresh_count", toggle_count, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t_input_conditioner.md
T_INPUT_CONDITIONER -- requirements
Module: t_input_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronized cycles needed to accept an edge; legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8, width of toggle_count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ena  input  1  design enable; low freezes the FSM and the counter.
REQ-006 SHALL have port t_raw  input  1  asynchronous, bouncy toggle request from a pad.
REQ-007 SHALL have port count_clr  input  1  synchronous clear of toggle_count.
REQ-008 SHALL have port t_pulse  output  1  one-cycle toggle strobe for the downstream T flip-flop.
REQ-009 SHALL have port t_level  output  1  debounced level of t_raw.
REQ-010 SHALL have port busy  output  1  high while an edge is being qualified.
REQ-011 SHALL have port toggle_count  output  CNT_W  number of accepted rising edges, modulo 2^CNT_W.

Function
REQ-012 SHALL pass t_raw through a two-flop synchronizer (t_sync); the synchronizer runs regardless of ena.
REQ-013 SHALL implement FSM states LOW, RISE_WAIT, HIGH and FALL_WAIT, plus a debounce counter cnt.
REQ-014 In LOW with t_sync=1, SHALL go to RISE_WAIT with cnt=0; otherwise SHALL stay in LOW.
REQ-015 In RISE_WAIT: t_sync=0 -> LOW (bounce rejected, no pulse); t_sync=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH; otherwise cnt+1.
REQ-016 HIGH/FALL_WAIT SHALL mirror REQ-014/015 with t_sync inverted; FALL_WAIT->LOW on qualification, FALL_WAIT->HIGH on bounce.
REQ-017 t_pulse SHALL be registered and high for exactly the one cycle following the RISE_WAIT->HIGH transition edge; falling edges SHALL NOT generate a pulse.
REQ-018 If t_raw rises and is stable before edge 0, t_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-019 t_level SHALL be 1 in HIGH and FALL_WAIT, and 0 in LOW and RISE_WAIT.
REQ-020 busy SHALL be 1 exactly in RISE_WAIT and FALL_WAIT.
REQ-021 toggle_count SHALL increment by 1 on each edge at which t_pulse is set, and SHALL wrap from 2^CNT_W-1 to 0.
REQ-022 count_clr SHALL set toggle_count to 0 at the next edge; when count_clr coincides with an increment, clear SHALL win (result 0).
REQ-023 With ena=0: state, cnt and toggle_count SHALL hold, and t_pulse SHALL be 0. On ena returning to 1, operation SHALL resume from the held state.
REQ-024 count_clr SHALL act even when ena=0.

Reset
REQ-025 rst=1 at a clock edge SHALL force: both synchronizer flops=0, state=LOW, cnt=0, t_pulse=0, t_level=0, busy=0, toggle_count=0.
REQ-026 rst SHALL take priority over ena, count_clr and any in-progress qualification; an edge being qualified when rst is asserted SHALL be discarded and SHALL NOT produce a pulse.

Verification (DEBOUNCE_CYCLES=4, CNT_W=8)
REQ-027 Clean press: rst then t_raw 0->1 held before edge 0 -> t_pulse=1 only after edge 6; t_level=1; toggle_count=1; busy=1 after edges 2..5.
REQ-028 Bounce: t_raw high for 2 cycles, low for 1, then high and held -> exactly one t_pulse; toggle_count=1.
REQ-029 Release bounce and wrap: 256 clean press/release cycles -> toggle_count=0; no pulse on any release.
REQ-030 Clear collision: count_clr=1 on the same edge t_pulse is set -> toggle_count=0 next cycle.
REQ-031 Freeze: ena=0 while in RISE_WAIT with cnt=2, t_raw held high for 10 cycles -> no pulse and state held; ena=1 -> pulse 2 cycles later.
REQ-032 Reset mid-qualification: rst=1 while in RISE_WAIT -> all outputs 0 next cycle, and no pulse until a fresh full qualification completes.
